mtc_rx_unpacker: RTL and testbench
==================================

Name: mtc_rx_unpacker

Overview:
- Receive end of the MTC-to-SL packet path. Takes the 128-bit MTC packet as MSB-first 32-bit words from the link, reassembles it, and checks framing and the reserved field.
- Unpacks the MDT process flags, which have the same 4-bit encoding as on the transmit side.
- Presents the packet on a valid/ready output and keeps saturating monitoring counters.
- Used on the SL-emulator / loopback path and in link monitoring.

Parameters:
- WORD_WIDTH, 32, link word width in bits
- MTC_PKT_WIDTH, 128, packet width; must be an integer multiple of WORD_WIDTH
- CNT_WIDTH, 16, width of each monitoring counter

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  WORD_WIDTH  link word
- in_valid  in  1  in_data is valid
- in_sof  in  1  marks the first word of a packet (bits [127:96])
- in_ready  out  1  a word is accepted when in_valid && in_ready
- mtc  out  MTC_PKT_WIDTH  reassembled packet
- mtc_valid  out  1  output packet pending
- mtc_ready  in  1  downstream accepts the packet
- procflags  out  4  mtc[MTC2SL_MDT_PROCFLAGS_MSB:LSB]
- mdt_pass  out  1  procflags == 1
- err_reserved  out  1  reserved field non-zero, qualified by mtc_valid
- err_flag  out  1  procflags is in 7..14, qualified by mtc_valid
- cnt_clear  in  1  synchronous clear of all counters
- cnt_pkt, cnt_pass, cnt_busy, cnt_frame_err, cnt_orphan  out  CNT_WIDTH each  monitoring counters

Behaviour:
- Reset values (rst low, asynchronous): state IDLE, word index 0, mtc 0, mtc_valid 0, procflags 0, mdt_pass 0, err_* 0, all counters 0.
- Derived: NW = MTC_PKT_WIDTH/WORD_WIDTH. Word k of a packet fills bits [MTC_PKT_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH].
- FSM state IDLE:
  - Accepted word with in_sof: store it as word 0, set idx=1, go to COLLECT.
  - Accepted word without in_sof: drop it, cnt_orphan += 1.
- FSM state COLLECT:
  - Accepted word without in_sof: store at idx, idx += 1.
  - On the word that makes idx == NW: transfer the assembly buffer to the output register, go to IDLE.
  - Accepted word with in_sof (premature start): cnt_frame_err += 1, discard the partial packet, store the word as word 0, idx=1, stay in COLLECT.
- Output register:
  - mtc_valid rises the cycle after the last word is accepted (latency 1 from the final word).
  - procflags, mdt_pass and err_* are registered together with mtc.
  - The output holds until mtc_valid && mtc_ready.
- in_ready:
  - Low only when the next accepted word would complete a packet (COLLECT, idx == NW-1) while the output is occupied and not draining (mtc_valid && !mtc_ready).
  - High in every other case, so words 0..NW-2 are still collected while the output stalls.
- Simultaneous events: when a completing word and an output handshake happen in the same cycle, the new packet replaces the old one with no bubble, and mtc_valid stays 1.
- Counters:
  - cnt_pkt, cnt_pass, cnt_busy increment when a packet is loaded into the output register, not on handshake.
  - cnt_busy counts packets with procflags == 0 (MDT busy / no MDT data).
  - All counters saturate at all-ones.
  - cnt_clear takes priority over an increment in the same cycle.
- Error flags are informational only; the packet is still delivered.
- Reset mid-packet: the partial packet is lost and the FSM returns to IDLE. The first accepted word after reset must carry in_sof, otherwise it counts as an orphan.

Decomposition:
- Field positions come from the shared buses constants header: MTC2SL_M_RESERVED_*, MTC2SL_MDT_PROCFLAGS_*, MTC2SL_COMMON_LSB.
- Add a procflags enum to the shared MTC package: NO_MDT=0, PASS=1, BELOW_THR=2, OTHER_BOARD=3, NOSEG=4, ONESEG=5, PT_FAIL=6, UNKNOWN=15.
- One sub-module, mtc_sat_counter: a saturating counter with clear, instantiated five times.

Test Plan:
- 4 back-to-back words 0xA0000001, 0x0, 0x0, 0x00000010 with SOF on the first, procflags field = 1, mtc_ready held 1 -> mtc_valid exactly 1 cycle after word 3, mtc = the 4 words concatenated, mdt_pass=1, cnt_pkt=1, cnt_pass=1.
- SOF, 2 more words, then a new SOF followed by a full 4-word packet -> cnt_frame_err=1, only the second packet is output, cnt_pkt=1.
- Word without SOF while IDLE -> dropped, cnt_orphan=1, no mtc_valid.
- mtc_ready=0 while two packets stream in:
  - in_ready drops only on the 4th word of packet 2.
  - Raising mtc_ready delivers packet 1, then packet 2 on the next cycle.
  - No words are lost.
- Packet with procflags=9 and a non-zero reserved field -> err_flag=1 and err_reserved=1 with mtc_valid; the packet is still delivered.
- Force cnt_pkt to 0xFFFF, send 1 packet -> stays 0xFFFF. Pulse cnt_clear in the same cycle as an increment -> 0. Assert rst low mid-packet -> all outputs 0 at once, FSM back in IDLE.

Source files
------------

// File: rtl/mtc_rx_unpacker_pkg.sv
// Shared MTC-to-SL definitions: packet field positions, MDT process-flag encoding
// and the receive FSM state type.
package mtc_rx_unpacker_pkg;

  localparam int MTC2SL_COMMON_LSB        = 96;
  localparam int MTC2SL_M_RESERVED_MSB    = 95;
  localparam int MTC2SL_M_RESERVED_LSB    = 88;
  localparam int MTC2SL_MDT_PROCFLAGS_MSB = 7;
  localparam int MTC2SL_MDT_PROCFLAGS_LSB = 4;
  localparam int PROCFLAGS_W = MTC2SL_MDT_PROCFLAGS_MSB - MTC2SL_MDT_PROCFLAGS_LSB + 1;

  typedef enum logic [PROCFLAGS_W-1:0] {
    NO_MDT      = 4'd0,
    PASS        = 4'd1,
    BELOW_THR   = 4'd2,
    OTHER_BOARD = 4'd3,
    NOSEG       = 4'd4,
    ONESEG      = 4'd5,
    PT_FAIL     = 4'd6,
    UNKNOWN     = 4'd15
  } procflags_e;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_e;

  // Codes 7..14 are unassigned on the transmit side.
  function automatic logic procflags_invalid(input logic [PROCFLAGS_W-1:0] pf);
    return (pf >= 4'd7) && (pf <= 4'd14);
  endfunction

endpackage

// File: rtl/mtc_rx_unpacker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module mtc_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mtc_rx_unpacker.sv
// Reassembles MSB-first link words into an MTC packet, checks framing and the
// reserved field, and presents the packet on a valid/ready output with counters.
module mtc_rx_unpacker
  import mtc_rx_unpacker_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int MTC_PKT_WIDTH = 128,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [WORD_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  output logic [MTC_PKT_WIDTH-1:0] mtc,
  output logic                     mtc_valid,
  input  logic                     mtc_ready,
  output logic [PROCFLAGS_W-1:0]   procflags,
  output logic                     mdt_pass,
  output logic                     err_reserved,
  output logic                     err_flag,
  input  logic                     cnt_clear,
  output logic [CNT_WIDTH-1:0]     cnt_pkt,
  output logic [CNT_WIDTH-1:0]     cnt_pass,
  output logic [CNT_WIDTH-1:0]     cnt_busy,
  output logic [CNT_WIDTH-1:0]     cnt_frame_err,
  output logic [CNT_WIDTH-1:0]     cnt_orphan
);

  localparam int NW    = MTC_PKT_WIDTH / WORD_WIDTH;
  localparam int IDX_W = $clog2(NW) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  rx_state_e                state;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         wr_idx;
  logic [MTC_PKT_WIDTH-1:0] asm_buf;
  logic [MTC_PKT_WIDTH-1:0] pkt_next;
  logic                     at_last;
  logic                     accept;
  logic                     store;
  logic                     complete;
  procflags_e               pf_next;
  logic                     rsv_nz_next;
  logic                     err_res_q;
  logic                     err_flag_q;

  // Stall only the completing word; earlier words keep flowing while the output waits.
  assign at_last  = (state == COLLECT) && (idx == LAST_IDX);
  assign in_ready = !(at_last && mtc_valid && !mtc_ready);
  assign accept   = in_valid && in_ready;
  assign store    = accept && (in_sof || (state == COLLECT));
  assign complete = accept && !in_sof && at_last;
  assign wr_idx   = in_sof ? '0 : idx;

  always_comb begin
    pkt_next = asm_buf;
    pkt_next[MTC_PKT_WIDTH - 1 - int'(wr_idx) * WORD_WIDTH -: WORD_WIDTH] = in_data;
  end

  assign pf_next     = procflags_e'(pkt_next[MTC2SL_MDT_PROCFLAGS_MSB:MTC2SL_MDT_PROCFLAGS_LSB]);
  assign rsv_nz_next = |pkt_next[MTC2SL_M_RESERVED_MSB:MTC2SL_M_RESERVED_LSB];

  // Assembly buffer: every slot is rewritten before a packet can complete.
  always_ff @(posedge clock) begin
    if (store) begin
      asm_buf <= pkt_next;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      mtc        <= '0;
      mtc_valid  <= 1'b0;
      procflags  <= '0;
      mdt_pass   <= 1'b0;
      err_res_q  <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      if (accept) begin
        if (in_sof) begin
          state <= COLLECT;
          idx   <= IDX_W'(1);
        end else if (state == COLLECT) begin
          if (at_last) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end

      // A new packet overrides the handshake so back-to-back delivery has no bubble.
      if (complete) begin
        mtc        <= pkt_next;
        mtc_valid  <= 1'b1;
        procflags  <= pf_next;
        mdt_pass   <= (pf_next == PASS);
        err_res_q  <= rsv_nz_next;
        err_flag_q <= procflags_invalid(pf_next);
      end else if (mtc_ready) begin
        mtc_valid <= 1'b0;
      end
    end
  end

  assign err_reserved = err_res_q && mtc_valid;
  assign err_flag     = err_flag_q && mtc_valid;

  mtc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_pkt (
    .clock (clock),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (complete),
    .count (cnt_pkt)
  );

  mtc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_pass (
    .clock (clock),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (complete && (pf_next == PASS)),
    .count (cnt_pass)
  );

  mtc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_busy (
    .clock (clock),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (complete && (pf_next == NO_MDT)),
    .count (cnt_busy)
  );

  mtc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_frame_err (
    .clock (clock),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (accept && in_sof && (state == COLLECT)),
    .count (cnt_frame_err)
  );

  mtc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_orphan (
    .clock (clock),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (accept && !in_sof && (state == IDLE)),
    .count (cnt_orphan)
  );

endmodule

// File: tb/tb_mtc_rx_unpacker.sv
// Directed bench for mtc_rx_unpacker: vector table for framing/flags plus
// hand sequences for backpressure, counter clear/saturation and mid-packet reset.
module tb_mtc_rx_unpacker;

  logic         clock = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid, in_sof, mtc_ready, cnt_clear;
  logic         in_ready, mtc_valid, mdt_pass, err_reserved, err_flag;
  logic [127:0] mtc;
  logic [3:0]   procflags;
  logic [15:0]  cnt_pkt, cnt_pass, cnt_busy, cnt_frame_err, cnt_orphan;

  logic         s_in_ready, s_mtc_valid, s_mdt_pass, s_err_reserved, s_err_flag;
  logic [127:0] s_mtc;
  logic [3:0]   s_procflags;
  logic [1:0]   s_cnt_pkt, s_cnt_pass, s_cnt_busy, s_cnt_frame_err, s_cnt_orphan;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mtc_rx_unpacker dut (
    .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .mtc(mtc), .mtc_valid(mtc_valid), .mtc_ready(mtc_ready),
    .procflags(procflags), .mdt_pass(mdt_pass), .err_reserved(err_reserved),
    .err_flag(err_flag), .cnt_clear(cnt_clear), .cnt_pkt(cnt_pkt), .cnt_pass(cnt_pass),
    .cnt_busy(cnt_busy), .cnt_frame_err(cnt_frame_err), .cnt_orphan(cnt_orphan)
  );

  // Narrow counters so saturation is reachable in a few packets.
  mtc_rx_unpacker #(.CNT_WIDTH(2)) dut_s (
    .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(s_in_ready), .mtc(s_mtc), .mtc_valid(s_mtc_valid), .mtc_ready(mtc_ready),
    .procflags(s_procflags), .mdt_pass(s_mdt_pass), .err_reserved(s_err_reserved),
    .err_flag(s_err_flag), .cnt_clear(cnt_clear), .cnt_pkt(s_cnt_pkt), .cnt_pass(s_cnt_pass),
    .cnt_busy(s_cnt_busy), .cnt_frame_err(s_cnt_frame_err), .cnt_orphan(s_cnt_orphan)
  );

  typedef struct {
    bit           v, sof, rdy;
    logic [31:0]  d;
    bit           e_ird, e_mv, e_pass, e_errr, e_errf;
    logic [127:0] e_mtc;
    logic [15:0]  e_pkt, e_passc, e_busyc, e_frame, e_orph;
  } vec_t;

  vec_t vq[$];

  function automatic void addv(input int v, input int sof, input logic [31:0] d, input int rdy,
                               input int ird, input int mv, input logic [127:0] m,
                               input int pass, input int errr, input int errf,
                               input int pkt, input int passc, input int busyc,
                               input int frame, input int orph);
    vec_t r;
    r.v = v[0]; r.sof = sof[0]; r.d = d; r.rdy = rdy[0];
    r.e_ird = ird[0]; r.e_mv = mv[0]; r.e_mtc = m;
    r.e_pass = pass[0]; r.e_errr = errr[0]; r.e_errf = errf[0];
    r.e_pkt = 16'(pkt); r.e_passc = 16'(passc); r.e_busyc = 16'(busyc);
    r.e_frame = 16'(frame); r.e_orph = 16'(orph);
    vq.push_back(r);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic sof, input logic [31:0] d);
    @(negedge clock);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_pkt(input logic [127:0] p);
    send(1'b1, p[127:96]);
    send(1'b0, p[95:64]);
    send(1'b0, p[63:32]);
    send(1'b0, p[31:0]);
  endtask

  localparam logic [127:0] P1 = 128'hA0000001_00000000_00000000_00000010;
  localparam logic [127:0] P2 = 128'hC0000002_00000000_00000000_00000000;
  localparam logic [127:0] P3 = 128'hE0000003_5A000000_00000000_00000090;
  localparam logic [127:0] Q1 = 128'h11000001_00000000_00000000_00000010;
  localparam logic [127:0] Q2 = 128'h22000002_00000000_00000000_00000020;
  localparam logic [127:0] Q3 = 128'h33000003_00000000_00000000_00000010;
  localparam logic [127:0] Q4 = 128'h44000004_00000000_00000000_00000000;
  localparam logic [127:0] Q5 = 128'h77000007_00000000_00000000_00000010;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] qw;
    logic [31:0]  w;

    // Well-formed packet, procflags PASS.
    addv(1,1,32'hA0000001,1, 1,0,128'h0,0,0,0, 0,0,0,0,0);
    addv(1,0,32'h00000000,1, 1,0,128'h0,0,0,0, 0,0,0,0,0);
    addv(1,0,32'h00000000,1, 1,0,128'h0,0,0,0, 0,0,0,0,0);
    addv(1,0,32'h00000010,1, 1,1,P1,   1,0,0, 1,1,0,0,0);
    addv(0,0,32'h00000000,1, 1,0,P1,   1,0,0, 1,1,0,0,0);
    // Premature SOF after three words, then a full busy packet.
    addv(1,1,32'hB0000001,1, 1,0,P1,   1,0,0, 1,1,0,0,0);
    addv(1,0,32'h11111111,1, 1,0,P1,   1,0,0, 1,1,0,0,0);
    addv(1,0,32'h22222222,1, 1,0,P1,   1,0,0, 1,1,0,0,0);
    addv(1,1,32'hC0000002,1, 1,0,P1,   1,0,0, 1,1,0,1,0);
    addv(1,0,32'h00000000,1, 1,0,P1,   1,0,0, 1,1,0,1,0);
    addv(1,0,32'h00000000,1, 1,0,P1,   1,0,0, 1,1,0,1,0);
    addv(1,0,32'h00000000,1, 1,1,P2,   0,0,0, 2,1,1,1,0);
    addv(0,0,32'h00000000,1, 1,0,P2,   0,0,0, 2,1,1,1,0);
    // Orphan word while idle.
    addv(1,0,32'hDEADBEEF,1, 1,0,P2,   0,0,0, 2,1,1,1,1);
    // Invalid procflags and non-zero reserved field.
    addv(1,1,32'hE0000003,1, 1,0,P2,   0,0,0, 2,1,1,1,1);
    addv(1,0,32'h5A000000,1, 1,0,P2,   0,0,0, 2,1,1,1,1);
    addv(1,0,32'h00000000,1, 1,0,P2,   0,0,0, 2,1,1,1,1);
    addv(1,0,32'h00000090,1, 1,1,P3,   0,1,1, 3,1,1,1,1);
    addv(0,0,32'h00000000,0, 1,1,P3,   0,1,1, 3,1,1,1,1);
    addv(0,0,32'h00000000,1, 1,0,P3,   0,0,0, 3,1,1,1,1);

    rst = 1'b0; in_data = '0; in_valid = 1'b0; in_sof = 1'b0;
    mtc_ready = 1'b1; cnt_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk1("reset mtc_valid", mtc_valid, 1'b0);
    chk128("reset mtc", mtc, 128'h0);
    chk16("reset procflags", 16'(procflags), 16'h0);
    chk1("reset mdt_pass", mdt_pass, 1'b0);
    chk16("reset cnt_pkt", cnt_pkt, 16'h0);
    chk16("reset cnt_orphan", cnt_orphan, 16'h0);
    chk1("reset in_ready", in_ready, 1'b1);
    @(negedge clock);
    rst = 1'b1;

    foreach (vq[i]) begin
      @(negedge clock);
      in_valid = vq[i].v; in_sof = vq[i].sof; in_data = vq[i].d; mtc_ready = vq[i].rdy;
      #1;
      chk1($sformatf("v%0d in_ready", i), in_ready, vq[i].e_ird);
      @(posedge clock);
      #1;
      chk1($sformatf("v%0d mtc_valid", i), mtc_valid, vq[i].e_mv);
      chk128($sformatf("v%0d mtc", i), mtc, vq[i].e_mtc);
      chk1($sformatf("v%0d mdt_pass", i), mdt_pass, vq[i].e_pass);
      chk1($sformatf("v%0d err_reserved", i), err_reserved, vq[i].e_errr);
      chk1($sformatf("v%0d err_flag", i), err_flag, vq[i].e_errf);
      chk16($sformatf("v%0d cnt_pkt", i), cnt_pkt, vq[i].e_pkt);
      chk16($sformatf("v%0d cnt_pass", i), cnt_pass, vq[i].e_passc);
      chk16($sformatf("v%0d cnt_busy", i), cnt_busy, vq[i].e_busyc);
      chk16($sformatf("v%0d cnt_frame_err", i), cnt_frame_err, vq[i].e_frame);
      chk16($sformatf("v%0d cnt_orphan", i), cnt_orphan, vq[i].e_orph);
    end
    in_valid = 1'b0;
    chk16("sat cnt_pkt after 3 pkts", 16'(s_cnt_pkt), 16'd3);

    // Output stalled while two packets stream in.
    mtc_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      qw = (k < 4) ? Q1 : Q2;
      w  = qw[127 - (k % 4) * 32 -: 32];
      @(negedge clock);
      in_valid = 1'b1; in_sof = ((k % 4) == 0); in_data = w;
      #1;
      chk1($sformatf("bp word%0d in_ready", k), in_ready, 1'b1);
      @(posedge clock);
      #1;
      if (k == 3) begin
        chk1("bp pkt1 mtc_valid", mtc_valid, 1'b1);
        chk128("bp pkt1 mtc", mtc, Q1);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      in_valid = 1'b1; in_sof = 1'b0; in_data = Q2[31:0];
      #1;
      chk1($sformatf("bp stall%0d in_ready", k), in_ready, 1'b0);
      chk128($sformatf("bp stall%0d mtc", k), mtc, Q1);
      @(posedge clock);
    end
    @(negedge clock);
    mtc_ready = 1'b1;
    #1;
    chk1("bp release in_ready", in_ready, 1'b1);
    chk1("bp release mtc_valid", mtc_valid, 1'b1);
    chk128("bp release mtc", mtc, Q1);
    @(posedge clock);
    #1;
    chk1("bp pkt2 mtc_valid", mtc_valid, 1'b1);
    chk128("bp pkt2 mtc", mtc, Q2);
    chk16("bp pkt2 procflags", 16'(procflags), 16'd2);
    chk16("bp cnt_pkt", cnt_pkt, 16'd5);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk1("bp drained mtc_valid", mtc_valid, 1'b0);
    chk16("bp cnt_pass", cnt_pass, 16'd2);
    chk16("bp cnt_busy", cnt_busy, 16'd1);
    chk16("sat cnt_pkt held", 16'(s_cnt_pkt), 16'd3);

    // Clear coincident with an increment.
    send(1'b1, Q3[127:96]);
    send(1'b0, Q3[95:64]);
    send(1'b0, Q3[63:32]);
    cnt_clear = 1'b1;
    send(1'b0, Q3[31:0]);
    cnt_clear = 1'b0;
    chk1("clr mtc_valid", mtc_valid, 1'b1);
    chk128("clr mtc", mtc, Q3);
    chk16("clr cnt_pkt", cnt_pkt, 16'd0);
    chk16("clr cnt_pass", cnt_pass, 16'd0);
    chk16("clr cnt_frame_err", cnt_frame_err, 16'd0);
    chk16("clr cnt_orphan", cnt_orphan, 16'd0);
    chk16("clr sat cnt_pkt", 16'(s_cnt_pkt), 16'd0);
    send_pkt(Q4);
    chk128("post-clr mtc", mtc, Q4);
    chk16("post-clr cnt_pkt", cnt_pkt, 16'd1);
    chk16("post-clr cnt_busy", cnt_busy, 16'd1);
    chk16("post-clr cnt_pass", cnt_pass, 16'd0);

    // Reset in the middle of a packet with the output occupied.
    mtc_ready = 1'b0;
    send(1'b1, 32'h55000005);
    send(1'b0, 32'h00000000);
    chk1("pre-rst mtc_valid", mtc_valid, 1'b1);
    @(negedge clock);
    #2;
    rst = 1'b0;
    #1;
    chk1("rst mtc_valid", mtc_valid, 1'b0);
    chk128("rst mtc", mtc, 128'h0);
    chk1("rst mdt_pass", mdt_pass, 1'b0);
    chk16("rst cnt_pkt", cnt_pkt, 16'd0);
    chk16("rst cnt_busy", cnt_busy, 16'd0);
    @(negedge clock);
    rst = 1'b1;
    mtc_ready = 1'b1;
    send(1'b0, 32'h66666666);
    chk16("post-rst cnt_orphan", cnt_orphan, 16'd1);
    chk1("post-rst orphan mtc_valid", mtc_valid, 1'b0);
    send_pkt(Q5);
    chk1("post-rst mtc_valid", mtc_valid, 1'b1);
    chk128("post-rst mtc", mtc, Q5);
    chk1("post-rst mdt_pass", mdt_pass, 1'b1);
    chk16("post-rst cnt_pkt", cnt_pkt, 16'd1);
    chk16("post-rst cnt_frame_err", cnt_frame_err, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
